// File: rtl/conv_rd_scheduler.sv
// conv_rd_scheduler: issues cacheline read requests for a convolution job.
//   The image is streamed in chunks of up to IMG_CHUNK_CL lines. After each
//   chunk the whole filter region is re-read in blocks of KBLK_CL lines into
//   alternating kernel half-buffers.
//   Latency: one request per cycle; outputs are registered (one-cycle delay from decision).
//   Backpressure: rd_req_almostfull=1 stalls issue and freezes pointers/counters.
//   A block waits in KWAIT until kbuf_free[H] is set.
// Ports:
//   clk, reset (sync, active-high), start
//   cfg_filter_offset  image size in lines == filter base address
//   cfg_num_cl_filter  filter size in lines
//   rd_req_almostfull  request channel backpressure
//   kbuf_free[1:0]     per-half write permission
//   rd_req_addr/rd_req_mdata/rd_req_en  request channel
//   kbuf_filled[1:0]   pulse: half fully requested
//   img_chunk_done     pulse: image chunk fully requested
//   done               job complete (level)
module conv_rd_scheduler #(
  parameter int ADDR_LMT     = 20,
  parameter int MDATA        = 14,
  parameter int IMG_CHUNK_CL = 8192,
  parameter int KBLK_CL      = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_LMT-1:0] cfg_filter_offset,
  input  logic [31:0]         cfg_num_cl_filter,
  input  logic                rd_req_almostfull,
  input  logic [1:0]          kbuf_free,
  output logic [ADDR_LMT-1:0] rd_req_addr,
  output logic [MDATA-1:0]    rd_req_mdata,
  output logic                rd_req_en,
  output logic [1:0]          kbuf_filled,
  output logic                img_chunk_done,
  output logic                done
);

  localparam int CCW = $clog2(IMG_CHUNK_CL + 1);
  localparam int BCW = $clog2(KBLK_CL + 1);
  // Filter end is compared one bit wider than the widest operand so that a
  // region ending exactly at 2^ADDR_LMT does not wrap to zero.
  localparam int EW  = ((ADDR_LMT > 32) ? ADDR_LMT : 32) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMAGE,
    S_KERNEL,
    S_KWAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_LMT-1:0] off_q, off_d;
  logic [31:0]         nf_q, nf_d;
  logic [ADDR_LMT-1:0] ip_q, ip_d;
  logic [ADDR_LMT-1:0] kp_q, kp_d;
  logic                h_q, h_d;
  logic [CCW-1:0]      chunk_cnt_q, chunk_cnt_d;
  logic [BCW-1:0]      blk_cnt_q, blk_cnt_d;

  logic [ADDR_LMT-1:0] addr_q, addr_d;
  logic [MDATA-1:0]    mdata_q, mdata_d;
  logic                en_q, en_d;
  logic [1:0]          kf_q, kf_d;
  logic                cd_q, cd_d;
  logic                done_q, done_d;

  logic                ip_lt;
  logic [EW-1:0]       filt_end;
  logic                kp_last;
  logic                blk_last;

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    nf_d        = nf_q;
    ip_d        = ip_q;
    kp_d        = kp_q;
    h_d         = h_q;
    chunk_cnt_d = chunk_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    addr_d      = addr_q;
    mdata_d     = mdata_q;
    en_d        = 1'b0;
    kf_d        = 2'b00;
    cd_d        = 1'b0;
    done_d      = done_q;

    ip_lt    = (ip_q < off_q);
    filt_end = EW'(off_q) + EW'(nf_q);
    // The line being issued this cycle is the last filter line.
    kp_last  = ((EW'(kp_q) + EW'(1)) >= filt_end);
    // The line being issued this cycle fills the current half-buffer.
    blk_last = ((blk_cnt_q + BCW'(1)) == BCW'(KBLK_CL));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          done_d = 1'b1;
        end
        if (start) begin
          off_d       = cfg_filter_offset;
          nf_d        = cfg_num_cl_filter;
          ip_d        = '0;
          h_d         = 1'b0;
          chunk_cnt_d = '0;
          blk_cnt_d   = '0;
          done_d      = 1'b0;
          state_d     = (cfg_filter_offset == '0) ? S_DONE : S_IMAGE;
        end
      end

      S_IMAGE: begin
        if (!rd_req_almostfull) begin
          if (!ip_lt || (chunk_cnt_q == CCW'(IMG_CHUNK_CL))) begin
            // Chunk boundary: a dead cycle that hands over to the filter pass.
            cd_d        = 1'b1;
            chunk_cnt_d = '0;
            kp_d        = off_q;
            if (nf_q != '0) begin
              state_d = S_KWAIT;
            end else if (ip_lt) begin
              state_d = S_IMAGE;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            en_d        = 1'b1;
            addr_d      = ip_q;
            mdata_d     = '0;
            ip_d        = ip_q + ADDR_LMT'(1);
            chunk_cnt_d = chunk_cnt_q + CCW'(1);
          end
        end
      end

      S_KWAIT: begin
        if (kbuf_free[h_q]) begin
          blk_cnt_d = '0;
          state_d   = S_KERNEL;
        end
      end

      S_KERNEL: begin
        if (!rd_req_almostfull) begin
          en_d       = 1'b1;
          addr_d     = kp_q;
          mdata_d    = '0;
          mdata_d[0] = 1'b1;
          mdata_d[1] = h_q;
          kp_d       = kp_q + ADDR_LMT'(1);
          blk_cnt_d  = blk_cnt_q + BCW'(1);
          // End of block is signalled together with its last request, so a
          // short final block is flagged the same way as a full one.
          if (blk_last || kp_last) begin
            kf_d[h_q] = 1'b1;
            h_d       = ~h_q;
            blk_cnt_d = '0;
            if (!kp_last) begin
              state_d = S_KWAIT;
            end else if (ip_lt) begin
              state_d = S_IMAGE;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      nf_q        <= '0;
      ip_q        <= '0;
      kp_q        <= '0;
      h_q         <= 1'b0;
      chunk_cnt_q <= '0;
      blk_cnt_q   <= '0;
      addr_q      <= '0;
      mdata_q     <= '0;
      en_q        <= 1'b0;
      kf_q        <= 2'b00;
      cd_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      nf_q        <= nf_d;
      ip_q        <= ip_d;
      kp_q        <= kp_d;
      h_q         <= h_d;
      chunk_cnt_q <= chunk_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      addr_q      <= addr_d;
      mdata_q     <= mdata_d;
      en_q        <= en_d;
      kf_q        <= kf_d;
      cd_q        <= cd_d;
      done_q      <= done_d;
    end
  end

  assign rd_req_addr    = addr_q;
  assign rd_req_mdata   = mdata_q;
  assign rd_req_en      = en_q;
  assign kbuf_filled    = kf_q;
  assign img_chunk_done = cd_q;
  assign done           = done_q;

endmodule

// File: tb/tb_conv_rd_scheduler.sv
`timescale 1ns/1ps
module tb_conv_rd_scheduler;
  localparam int AW = 20;
  localparam int MW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] cfg_filter_offset;
  logic [31:0]   cfg_num_cl_filter;
  logic          rd_req_almostfull;
  logic [1:0]    kbuf_free;
  logic [AW-1:0] rd_req_addr;
  logic [MW-1:0] rd_req_mdata;
  logic          rd_req_en;
  logic [1:0]    kbuf_filled;
  logic          img_chunk_done;
  logic          done;

  always #5 clk = ~clk;

  conv_rd_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .cfg_filter_offset (cfg_filter_offset),
    .cfg_num_cl_filter (cfg_num_cl_filter),
    .rd_req_almostfull (rd_req_almostfull),
    .kbuf_free         (kbuf_free),
    .rd_req_addr       (rd_req_addr),
    .rd_req_mdata      (rd_req_mdata),
    .rd_req_en         (rd_req_en),
    .kbuf_filled       (kbuf_filled),
    .img_chunk_done    (img_chunk_done),
    .done              (done)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Trace entry: kind (1=request, 2=kbuf_filled, 3=img_chunk_done), mdata, addr.
  typedef logic [63:0] ent_t;
  ent_t got[$];
  ent_t exp_q[$];

  function automatic ent_t mk(input int kind, input int md, input int addr);
    return {8'(kind), 8'h00, 16'(md), 32'(addr)};
  endfunction

  logic mon_on = 1'b0;
  logic af_s   = 1'b0;
  int   stall_viol = 0;
  int   af_cycles  = 0;
  int   kf_seen    = 0;

  always @(posedge clk) af_s <= rd_req_almostfull;

  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_req_en) got.push_back(mk(1, int'(rd_req_mdata), int'(rd_req_addr)));
      if (kbuf_filled != 2'b00) begin
        got.push_back(mk(2, int'(kbuf_filled), 0));
        kf_seen++;
      end
      if (img_chunk_done) got.push_back(mk(3, 0, 0));
      if (af_s) af_cycles++;
      if (af_s && rd_req_en) stall_viol++;
    end
  end

  task automatic exp_img(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(mk(1, 0, a));
  endtask

  task automatic exp_ker(input int lo, input int hi, input int h);
    for (int a = lo; a <= hi; a++) exp_q.push_back(mk(1, 1 | (h << 1), a));
  endtask

  task automatic exp_kf(input int v);
    exp_q.push_back(mk(2, v, 0));
  endtask

  task automatic exp_cd();
    exp_q.push_back(mk(3, 0, 0));
  endtask

  // Pulse start for one cycle, then scramble cfg: captured values must be used.
  task automatic begin_job(input int off, input int nf);
    @(negedge clk);
    got.delete();
    exp_q.delete();
    stall_viol = 0;
    af_cycles  = 0;
    kf_seen    = 0;
    mon_on     = 1'b1;
    cfg_filter_offset = AW'(off);
    cfg_num_cl_filter = 32'(nf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_filter_offset = 20'hABCDE;
    cfg_num_cl_filter = 32'd77;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic cmp_seq(input string tag);
    int mism;
    int n;
    mism = 0;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < n; i++) begin
      if (got[i] !== exp_q[i]) begin
        if (mism == 0)
          $display("note %s: first difference at entry %0d got %h exp %h", tag, i, got[i], exp_q[i]);
        mism++;
      end
    end
    chk({tag, "_entries"}, 64'(mism), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    64'(rd_req_en),      64'd0);
    chk({tag, "_addr"},  64'(rd_req_addr),    64'd0);
    chk({tag, "_mdata"}, 64'(rd_req_mdata),   64'd0);
    chk({tag, "_kf"},    64'(kbuf_filled),    64'd0);
    chk({tag, "_cd"},    64'(img_chunk_done), 64'd0);
    chk({tag, "_done"},  64'(done),           64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg_filter_offset = '0;
    cfg_num_cl_filter = '0;
    rd_req_almostfull = 1'b0;
    kbuf_free = 2'b00;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;

    // Small job; a second start mid-run must be ignored.
    kbuf_free = 2'b11;
    begin_job(4, 3);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t1", 100);
    exp_img(0, 3); exp_cd(); exp_ker(4, 6, 0); exp_kf(1);
    cmp_seq("t1");

    // Backpressure for 5 cycles mid-image.
    begin_job(20, 1);
    repeat (5) @(negedge clk);
    rd_req_almostfull = 1'b1;
    repeat (5) @(negedge clk);
    rd_req_almostfull = 1'b0;
    wait_done("t2", 200);
    exp_img(0, 19); exp_cd(); exp_ker(20, 20, 0); exp_kf(1);
    cmp_seq("t2");
    chk("t2_stall_en", 64'(stall_viol), 64'd0);
    chk("t2_af_cycles", 64'(af_cycles), 64'd5);

    // Empty filter: image only.
    begin_job(3, 0);
    wait_done("t3", 100);
    exp_img(0, 2); exp_cd();
    cmp_seq("t3");

    // Two image chunks, filter re-read per chunk with alternating halves.
    begin_job(10000, 2);
    wait_done("t4", 12000);
    exp_img(0, 8191); exp_cd(); exp_ker(10000, 10001, 0); exp_kf(1);
    exp_img(8192, 9999); exp_cd(); exp_ker(10000, 10001, 1); exp_kf(2);
    cmp_seq("t4");

    // Multi-block filter, half 1 withheld until released.
    kbuf_free = 2'b01;
    begin_job(2, 600);
    for (int i = 0; i < 400 && kf_seen < 1; i++) @(negedge clk);
    chk("t5_first_block", 64'(kf_seen >= 1), 64'd1);
    repeat (30) @(negedge clk);
    chk("t5_stall_cnt", 64'(got.size()), 64'd260);
    chk("t5_stall_en", 64'(rd_req_en), 64'd0);
    kbuf_free = 2'b11;
    wait_done("t5", 1000);
    exp_img(0, 1); exp_cd();
    exp_ker(2, 257, 0); exp_kf(1);
    exp_ker(258, 513, 1); exp_kf(2);
    exp_ker(514, 601, 0); exp_kf(1);
    cmp_seq("t5");

    // Zero-size image restarted from DONE.
    begin_job(0, 5);
    chk("t6_done_cleared", 64'(done), 64'd0);
    @(negedge clk);
    chk("t6_done_set", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    chk("t6_no_req", 64'(got.size()), 64'd0);

    // Reset while issuing the second kernel block (H=1).
    kbuf_free = 2'b11;
    begin_job(4, 600);
    for (int i = 0; i < 400 && kf_seen < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t7_in_kernel_en", 64'(rd_req_en), 64'd1);
    chk("t7_in_kernel_md", 64'(rd_req_mdata), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("t7_rst");
    reset = 1'b0;
    begin_job(2, 1);
    wait_done("t7", 100);
    exp_img(0, 1); exp_cd(); exp_ker(2, 2, 0); exp_kf(1);
    cmp_seq("t7");

    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
